// File: rtl/filt_pass_sequencer.sv
// filt_pass_sequencer
// Runs a configurable number of in-place filter passes over one BRAM per
// frame, alternating horizontal/vertical direction. Upstream it behaves like
// a single filter engine (start/index/idle); downstream it launches the
// real engine once per pass and waits for each busy period to complete.
// Also reports the cycle count of the last completed frame.
// Optional watchdog: define FILT_PASS_TIMEOUT_EN to abort a frame whose
// current pass exceeds TIMEOUT_CYCLES (sets sticky err_timeout).
module filt_pass_sequencer #(
  parameter int MAX_PASSES     = 7,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_in,
  input  logic                            index_in,
  input  logic [2:0]                      cfg_num_passes,
  output logic                            idle_out,
  output logic                            pass_start,
  output logic                            pass_index,
  output logic                            pass_dir,
  output logic [$clog2(MAX_PASSES+1)-1:0] pass_num,
  input  logic                            engine_idle,
  output logic [23:0]                     last_frame_cycles,
  output logic                            err_timeout
);

  localparam int PW = $clog2(MAX_PASSES + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_DONE
  } state_t;

  state_t        state_reg;
  logic          idle_reg;
  logic          start_reg;
  logic          index_reg;
  logic [PW-1:0] pass_num_reg;
  logic [PW-1:0] num_passes_reg;
  logic [23:0]   frame_cnt_reg;
  logic [23:0]   last_cycles_reg;

  logic [PW-1:0] count_clamped;
  logic [23:0]   frame_cnt_next;
  logic          last_pass;
  logic          in_wait;
  logic          timeout_hit;

  // Pass count requested by the control FSM, limited to what we support
  always_comb begin
    count_clamped = PW'(cfg_num_passes);
    if (32'(cfg_num_passes) > MAX_PASSES) begin
      count_clamped = PW'(MAX_PASSES);
    end
  end

  // Frame cycle count including the current cycle; sticks at all-ones
  assign frame_cnt_next = (frame_cnt_reg == 24'hFF_FFFF) ? frame_cnt_reg
                                                         : frame_cnt_reg + 24'd1;

  assign last_pass = (pass_num_reg == (num_passes_reg - PW'(1)));
  assign in_wait   = (state_reg == ST_WAIT_BUSY) || (state_reg == ST_WAIT_DONE);

`ifdef FILT_PASS_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] wd_cnt_reg;
  logic           err_reg;

  // Fires on the cycle the per-pass count would reach TIMEOUT_CYCLES
  assign timeout_hit = in_wait && (wd_cnt_reg == WDW'(TIMEOUT_CYCLES - 1));

  // Per-pass watchdog: restarts at each launch, runs while waiting on the engine
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (state_reg == ST_LAUNCH) begin
        wd_cnt_reg <= '0;
      end else if (in_wait) begin
        wd_cnt_reg <= wd_cnt_reg + WDW'(1);
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err_timeout = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Pass sequencing FSM with registered handshake outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      idle_reg        <= 1'b1;
      start_reg       <= 1'b0;
      index_reg       <= 1'b0;
      pass_num_reg    <= '0;
      num_passes_reg  <= '0;
      frame_cnt_reg   <= '0;
      last_cycles_reg <= '0;
    end else begin
      if (state_reg != ST_IDLE) begin
        frame_cnt_reg <= frame_cnt_next;
      end

      if (timeout_hit) begin
        // Abandon the rest of the frame; the engine only sees pass_start drop
        state_reg       <= ST_IDLE;
        idle_reg        <= 1'b1;
        start_reg       <= 1'b0;
        last_cycles_reg <= frame_cnt_next;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_in) begin
              index_reg      <= index_in;
              num_passes_reg <= count_clamped;
              pass_num_reg   <= '0;
              frame_cnt_reg  <= '0;
              idle_reg       <= 1'b0;
              if (count_clamped != '0) begin
                state_reg <= ST_LAUNCH;
                start_reg <= 1'b1;
              end else begin
                state_reg <= ST_DONE;
              end
            end
          end

          ST_LAUNCH: begin
            state_reg <= ST_WAIT_BUSY;
          end

          ST_WAIT_BUSY: begin
            // Hold the launch request until the engine acknowledges by going busy
            if (!engine_idle) begin
              state_reg <= ST_WAIT_DONE;
              start_reg <= 1'b0;
            end
          end

          ST_WAIT_DONE: begin
            if (engine_idle) begin
              if (last_pass) begin
                state_reg       <= ST_IDLE;
                idle_reg        <= 1'b1;
                last_cycles_reg <= frame_cnt_next;
              end else begin
                pass_num_reg <= pass_num_reg + PW'(1);
                state_reg    <= ST_LAUNCH;
                start_reg    <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            // Zero-pass frame: one non-idle cycle so upstream sees the handshake
            state_reg       <= ST_IDLE;
            idle_reg        <= 1'b1;
            last_cycles_reg <= frame_cnt_next;
          end

          default: begin
            state_reg <= ST_IDLE;
            idle_reg  <= 1'b1;
            start_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign idle_out          = idle_reg;
  assign pass_start        = start_reg;
  assign pass_index        = index_reg;
  assign pass_num          = pass_num_reg;
  assign pass_dir          = pass_num_reg[0];
  assign last_frame_cycles = last_cycles_reg;

endmodule

// File: tb/tb_filt_pass_sequencer.sv
// tb_filt_pass_sequencer
// Directed bench with a behavioural filter engine and a scoreboard of
// expected pass launches. Define FILT_PASS_TIMEOUT_EN to cover the watchdog.
module tb_filt_pass_sequencer;

  localparam int MAXP      = 4;
  localparam int TMO       = 100;
  localparam int PW        = $clog2(MAXP + 1);
  localparam int ENG_DELAY = 3;   // cycles from pass_start to engine busy
  localparam int ENG_BUSY  = 10;  // engine busy duration
  localparam int PASS_CYC  = ENG_DELAY + ENG_BUSY + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_in;
  logic          index_in;
  logic [2:0]    cfg_num_passes;
  logic          idle_out;
  logic          pass_start;
  logic          pass_index;
  logic          pass_dir;
  logic [PW-1:0] pass_num;
  logic          engine_idle;
  logic [23:0]   last_frame_cycles;
  logic          err_timeout;

  always #5 clk = ~clk;

  filt_pass_sequencer #(
    .MAX_PASSES    (MAXP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start_in         (start_in),
    .index_in         (index_in),
    .cfg_num_passes   (cfg_num_passes),
    .idle_out         (idle_out),
    .pass_start       (pass_start),
    .pass_index       (pass_index),
    .pass_dir         (pass_dir),
    .pass_num         (pass_num),
    .engine_idle      (engine_idle),
    .last_frame_cycles(last_frame_cycles),
    .err_timeout      (err_timeout)
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int   num;
    logic dir;
    logic idx;
  } pass_t;

  pass_t sb_q[$];
  int    exp_burst_len = ENG_DELAY + 1;
  bit    eng_hold = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_passes(input int n, input logic idx);
    pass_t p;
    for (int k = 0; k < n; k++) begin
      p.num = k;
      p.dir = logic'(k & 1);
      p.idx = idx;
      sb_q.push_back(p);
    end
  endtask

  // Behavioural engine: goes busy ENG_DELAY cycles after seeing pass_start
  int eng_phase;
  int eng_cnt;
  always @(posedge clk) begin
    if (reset) begin
      eng_phase   <= 0;
      eng_cnt     <= 0;
      engine_idle <= 1'b1;
    end else begin
      case (eng_phase)
        0: if (pass_start && !eng_hold) begin
          eng_phase <= 1;
          eng_cnt   <= ENG_DELAY - 2;
        end
        1: if (eng_cnt == 0) begin
          engine_idle <= 1'b0;
          eng_phase   <= 2;
          eng_cnt     <= ENG_BUSY - 1;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
        default: if (eng_cnt == 0) begin
          engine_idle <= 1'b1;
          eng_phase   <= 0;
        end else begin
          eng_cnt <= eng_cnt - 1;
        end
      endcase
    end
  end

  // Launch monitor: each pass_start burst pops one expected pass
  logic  ps_prev = 1'b0;
  int    burst_len = 0;
  pass_t got;
  always @(negedge clk) begin
    if (reset) begin
      ps_prev   = 1'b0;
      burst_len = 0;
    end else begin
      if (pass_start && !ps_prev) begin
        chk("pass_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          got = sb_q.pop_front();
          chk("pass_num", 32'(pass_num), 32'(got.num));
          chk("pass_dir", 32'(pass_dir), 32'(got.dir));
          chk("pass_index", 32'(pass_index), 32'(got.idx));
          $display("launch pass_num=%0d dir=%0d index=%0d", pass_num, pass_dir, pass_index);
        end
      end
      if (pass_start) begin
        burst_len++;
      end else if (ps_prev) begin
        chk("burst_len", 32'(burst_len), 32'(exp_burst_len));
        burst_len = 0;
      end
      ps_prev = pass_start;
    end
  end

  // Run one complete frame and check its span and reported cycle count
  task automatic run_frame(input logic [2:0] cfg, input logic idx, input int exp_passes);
    int span;
    int exp_cyc;
    exp_cyc = (exp_passes == 0) ? 1 : exp_passes * PASS_CYC;
    push_passes(exp_passes, idx);
    @(posedge clk); #1;
    start_in = 1'b1; cfg_num_passes = cfg; index_in = idx;
    @(posedge clk); #1;
    start_in = 1'b0;
    @(negedge clk);
    chk("start_idle_low", 32'(idle_out), 32'd0);
    chk("start_pass_start", 32'(pass_start), 32'(exp_passes > 0));
    span = 1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (idle_out) break;
      span++;
    end
    chk("frame_idle_back", 32'(idle_out), 32'd1);
    chk("frame_span", 32'(span), 32'(exp_cyc));
    chk("last_frame_cycles", 32'(last_frame_cycles), 32'(exp_cyc));
    chk("passes_all_seen", 32'(sb_q.size()), 32'd0);
    $display("frame cfg=%0d idx=%0d passes=%0d span=%0d last_frame_cycles=%0d",
             cfg, idx, exp_passes, span, last_frame_cycles);
  endtask

  initial begin
    reset = 1'b1; start_in = 1'b0; index_in = 1'b0; cfg_num_passes = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_idle_out", 32'(idle_out), 32'd1);
    chk("rst_pass_start", 32'(pass_start), 32'd0);
    chk("rst_pass_index", 32'(pass_index), 32'd0);
    chk("rst_pass_dir", 32'(pass_dir), 32'd0);
    chk("rst_pass_num", 32'(pass_num), 32'd0);
    chk("rst_last_cycles", 32'(last_frame_cycles), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single, three and zero pass frames
    run_frame(3'd1, 1'b1, 1);
    run_frame(3'd3, 1'b0, 3);
    run_frame(3'd0, 1'b1, 0);

    // Mid-frame start pulses and config changes must be ignored
    fork
      run_frame(3'd2, 1'b0, 2);
      begin
        repeat (6) @(posedge clk); #1;
        start_in = 1'b1; cfg_num_passes = 3'd4; index_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        repeat (8) @(posedge clk); #1;
        start_in = 1'b1;
        @(posedge clk); #1;
        start_in = 1'b0;
        @(negedge clk);
        chk("latched_index", 32'(pass_index), 32'd0);
      end
    join

    // Pass count above MAX_PASSES clamps
    run_frame(3'd7, 1'b1, MAXP);

    // Reset during pass 1 of 3
    push_passes(3, 1'b1);
    @(posedge clk); #1;
    start_in = 1'b1; cfg_num_passes = 3'd3; index_in = 1'b1;
    @(posedge clk); #1;
    start_in = 1'b0;
    for (int i = 0; i < 200 && pass_num != PW'(1); i++) @(negedge clk);
    chk("reach_pass1", 32'(pass_num), 32'd1);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_idle_out", 32'(idle_out), 32'd1);
    chk("midrst_pass_start", 32'(pass_start), 32'd0);
    chk("midrst_pass_num", 32'(pass_num), 32'd0);
    chk("midrst_pass_index", 32'(pass_index), 32'd0);
    chk("midrst_last_cycles", 32'(last_frame_cycles), 32'd0);
    sb_q.delete();
    $display("reset mid-frame applied");

    // Reset and start together: reset wins
    @(posedge clk); #1;
    reset = 1'b1; start_in = 1'b1; cfg_num_passes = 3'd2;
    @(posedge clk); #1;
    reset = 1'b0; start_in = 1'b0;
    @(negedge clk);
    chk("rst_start_idle", 32'(idle_out), 32'd1);
    chk("rst_start_pass_start", 32'(pass_start), 32'd0);
    $display("reset with start applied");

    run_frame(3'd1, 1'b0, 1);

`ifdef FILT_PASS_TIMEOUT_EN
    // Engine never responds: watchdog aborts the frame
    eng_hold = 1'b1;
    exp_burst_len = TMO + 1;
    push_passes(1, 1'b0);
    @(posedge clk); #1;
    start_in = 1'b1; cfg_num_passes = 3'd1; index_in = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (TMO) @(posedge clk);
    #1;
    chk("wd_before_idle", 32'(idle_out), 32'd0);
    chk("wd_before_err", 32'(err_timeout), 32'd0);
    @(posedge clk); #1;
    chk("wd_idle", 32'(idle_out), 32'd1);
    chk("wd_err", 32'(err_timeout), 32'd1);
    chk("wd_pass_start", 32'(pass_start), 32'd0);
    chk("wd_last_cycles", 32'(last_frame_cycles), 32'(TMO + 1));
    @(negedge clk); #2;
    exp_burst_len = ENG_DELAY + 1;
    eng_hold = 1'b0;
    $display("watchdog frame err_timeout=%0d", err_timeout);
    run_frame(3'd2, 1'b1, 2);
    chk("wd_err_sticky", 32'(err_timeout), 32'd1);
`else
    // Engine never responds: block keeps waiting, no error
    eng_hold = 1'b1;
    push_passes(1, 1'b0);
    @(posedge clk); #1;
    start_in = 1'b1; cfg_num_passes = 3'd1; index_in = 1'b0;
    @(posedge clk); #1;
    start_in = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("hold_idle", 32'(idle_out), 32'd0);
    chk("hold_pass_start", 32'(pass_start), 32'd1);
    chk("hold_err", 32'(err_timeout), 32'd0);
    $display("stuck engine held idle_out=%0d err_timeout=%0d", idle_out, err_timeout);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    eng_hold = 1'b0;
    sb_q.delete();
    run_frame(3'd2, 1'b1, 2);
    chk("hold_err_after", 32'(err_timeout), 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
